// File: rtl/strong_override_ctrl_if.sv
// ---------------------------------------------------------------------------
// strong_override_ctrl_if
// Groups the request handshake, strong-driver controls and bus read-back
// signals of strong_override_ctrl.
//   master : request side / environment (drives req, req_val, bus_in)
//   slave  : the controller (drives ack, busy, drv_en, drv_val, mismatch,
//            err_cnt)
// Parameter W : width of the shared strength-resolved bus.
// ---------------------------------------------------------------------------
interface strong_override_ctrl_if #(
  parameter int W = 100
);
  logic         req;
  logic [W-1:0] req_val;
  logic         ack;
  logic         busy;
  logic         drv_en;
  logic [W-1:0] drv_val;
  logic [W-1:0] bus_in;
  logic         mismatch;
  logic [7:0]   err_cnt;

  modport master (
    output req, req_val, bus_in,
    input  ack, busy, drv_en, drv_val, mismatch, err_cnt
  );

  modport slave (
    input  req, req_val, bus_in,
    output ack, busy, drv_en, drv_val, mismatch, err_cnt
  );
endinterface

// File: rtl/strong_override_ctrl.sv
// ---------------------------------------------------------------------------
// strong_override_ctrl
// Drives a value strongly onto a shared strength-resolved bus for a fixed
// number of cycles, optionally verifying the resolved bus reads back the
// driven value.
//
// Ports:
//   clk      : sole clock, rising edge
//   rst      : synchronous, active-high reset
//   bus      : strong_override_ctrl_if.slave
//     req      (in)  request an override, honoured only in IDLE
//     req_val  (in)  value to drive, captured on acceptance
//     ack      (out) one-cycle pulse in RELEASE
//     busy     (out) high outside IDLE
//     drv_en   (out) strong driver enable (SETTLE and CHECK)
//     drv_val  (out) strong driver value, held after release
//     bus_in   (in)  resolved bus read back
//     mismatch (out) one-cycle pulse after a failed compare
//     err_cnt  (out) saturating count of mismatch pulses
//
// Parameters: W (bus width), HOLD (compare cycles, 1..255).
// Build option: define STRONG_OVERRIDE_CHECK_EN to enable read-back checking;
// otherwise mismatch/err_cnt are tied to 0 and bus_in is ignored.
//
// Timing, with the accept cycle as cycle 0: SETTLE cycle 1, CHECK cycles
// 2..HOLD+1, RELEASE (ack) cycle HOLD+2, next acceptance at HOLD+3 at the
// earliest.
// ---------------------------------------------------------------------------
module strong_override_ctrl #(
  parameter int W    = 100,
  parameter int HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  strong_override_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CHECK   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [W-1:0] drv_val_q, drv_val_d;

  // Next state and datapath capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drv_val_d = drv_val_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          drv_val_d = bus.req_val;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d   = HOLD_M1;
        state_d = CHECK;
      end
      CHECK: begin
        // counter reaching 0 marks the last of HOLD compare cycles
        if (cnt_q == 8'd0) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      drv_val_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drv_val_q <= drv_val_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.drv_en  = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.ack     = (state_q == RELEASE);
  assign bus.drv_val = drv_val_q;

`ifdef STRONG_OVERRIDE_CHECK_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       mismatch_q, mismatch_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Read-back compare; result is registered so the pulse lands one cycle
  // after the compared cycle.
  always_comb begin
    mismatch_d = (state_q == CHECK) && (bus.bus_in != drv_val_q);
    err_cnt_d  = mismatch_d ? sat_inc8(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_cnt_q;
`else
  assign bus.mismatch = 1'b0;
  assign bus.err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_strong_override_ctrl.sv
// ---------------------------------------------------------------------------
// tb_strong_override_ctrl
// Randomized bench for strong_override_ctrl (W=100, HOLD=4). The reference
// model tracks only "cycles since acceptance" and derives every output from
// that phase number; the bus environment mirrors the expected driver output
// and can corrupt the read-back during the compare window.
// ---------------------------------------------------------------------------
module tb_strong_override_ctrl;
  localparam int W    = 100;
  localparam int HOLD = 4;
`ifdef STRONG_OVERRIDE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // bus environment modes
  localparam int M_MIRROR = 0;
  localparam int M_BIT50  = 1;
  localparam int M_INVERT = 2;
  localparam int M_RAND   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  strong_override_ctrl_if #(.W(W)) sif ();

  strong_override_ctrl #(.W(W), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int checks = 0;
  int errors = 0;

  // reference model: m_t = 0 idle, else cycles since acceptance
  int           m_t   = 0;
  logic [W-1:0] m_val = '0;
  bit           m_mis = 1'b0;
  int           m_err = 0;

  int cyc      = 0;
  int acc_cyc  = 0;
  int last_ack = -1;
  int ack_cnt  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom};
    return x[W-1:0];
  endfunction

  task automatic step(input logic r, input logic q, input logic [W-1:0] qv, input int mode);
    logic [W-1:0] mirror;
    logic [W-1:0] b;
    logic [W-1:0] one;
    bit           in_chk;
    one = 1;
    @(negedge clk);
    check("busy",     W'(sif.busy),     W'(m_t != 0));
    check("drv_en",   W'(sif.drv_en),   W'(m_t >= 1 && m_t <= HOLD + 1));
    check("ack",      W'(sif.ack),      W'(m_t == HOLD + 2));
    check("drv_val",  sif.drv_val,      m_val);
    check("mismatch", W'(sif.mismatch), W'(m_mis));
    check("err_cnt",  W'(sif.err_cnt),  W'(m_err));
    if (sif.ack === 1'b1) begin
      last_ack = cyc;
      ack_cnt++;
    end
    mirror = (m_t >= 1 && m_t <= HOLD + 1) ? m_val : '0;
    in_chk = (m_t >= 2 && m_t <= HOLD + 1);
    case (mode)
      M_MIRROR: b = mirror;
      M_BIT50:  b = in_chk ? (mirror & ~(one << 50)) : mirror;
      M_INVERT: b = in_chk ? ~mirror : mirror;
      default:  b = (in_chk && $urandom_range(0, 3) == 0) ?
                    (mirror ^ (one << $urandom_range(0, W - 1))) : mirror;
    endcase
    rst         = r;
    sif.req     = q;
    sif.req_val = qv;
    sif.bus_in  = b;
    if (!r && q && m_t == 0) acc_cyc = cyc;
    @(posedge clk);
    if (r) begin
      m_t   = 0;
      m_val = '0;
      m_mis = 1'b0;
      m_err = 0;
    end else begin
      m_mis = CHECK_EN && in_chk && (b != m_val);
      if (m_mis && m_err < 255) m_err++;
      if (m_t == 0) begin
        if (q) begin
          m_t   = 1;
          m_val = qv;
        end
      end else if (m_t == HOLD + 2) begin
        m_t = 0;
      end else begin
        m_t++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_val(), mode);
  endtask

  initial begin
    int a0;
    logic [W-1:0] ones;
    ones        = '1;
    sif.req     = 1'b0;
    sif.req_val = '0;
    sif.bus_in  = '0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);

    // reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, M_MIRROR);
    idle(2, M_MIRROR);

    // single override, clean read-back
    step(1'b0, 1'b1, ones, M_MIRROR);
    idle(10, M_MIRROR);
    check("lat_clean", W'(last_ack - acc_cyc), W'(HOLD + 2));

    // bit 50 stuck low during the compare window
    step(1'b0, 1'b1, ones, M_BIT50);
    idle(10, M_BIT50);
    check("lat_bit50", W'(last_ack - acc_cyc), W'(HOLD + 2));
    check("err_bit50", W'(sif.err_cnt), CHECK_EN ? W'(4) : W'(0));

    // req held high, req_val changing every cycle
    a0 = ack_cnt;
    for (int i = 0; i < 3 * (HOLD + 3); i++) step(1'b0, 1'b1, rand_val(), M_MIRROR);
    check("acks_held", W'(ack_cnt - a0), W'(3));
    idle(8, M_MIRROR);

    // reset two cycles after acceptance
    step(1'b0, 1'b1, rand_val(), M_MIRROR);
    step(1'b0, 1'b0, rand_val(), M_MIRROR);
    a0 = ack_cnt;
    step(1'b1, 1'b0, rand_val(), M_MIRROR);
    idle(10, M_MIRROR);
    check("acks_abort", W'(ack_cnt - a0), W'(0));

    // reset wins over a simultaneous req
    step(1'b1, 1'b1, rand_val(), M_MIRROR);
    idle(3, M_MIRROR);
    check("busy_rstreq", W'(sif.busy), W'(0));

    // saturation: 80 overrides x HOLD failing compares
    step(1'b1, 1'b0, '0, M_MIRROR);
    for (int i = 0; i < 80 * (HOLD + 3); i++) step(1'b0, 1'b1, rand_val(), M_INVERT);
    idle(8, M_INVERT);
    check("err_sat", W'(sif.err_cnt), CHECK_EN ? W'(255) : W'(0));

    // random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0), 1'(($urandom & 1)), rand_val(),
           ($urandom_range(0, 7) == 0) ? M_BIT50 : M_RAND);
    end
    idle(10, M_MIRROR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/strong_override_ctrl.md
STRONG_OVERRIDE_CTRL -- requirements
Module: strong_override_ctrl

Interface
REQ-001 SHALL have parameter W, default 100: width of the shared strength-resolved bus.
REQ-002 SHALL have parameter HOLD, default 4: number of check cycles the strong drive is held (legal 1..255).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 1: request to strongly override the bus.
REQ-006 SHALL have port req_val, input, W: value to drive strongly; sampled when req is accepted.
REQ-007 SHALL have port ack, output, 1: one-cycle pulse marking completion of an override.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port drv_en, output, 1: enable for the downstream (strong0, strong1) driver.
REQ-010 SHALL have port drv_val, output, W: value for the strong driver.
REQ-011 SHALL have port bus_in, input, W: resolved bus read back (weak default 0 plus strong driver).
REQ-012 SHALL have port mismatch, output, 1: one-cycle pulse on a failed read-back compare.
REQ-013 SHALL have port err_cnt, output, 8: saturating count of mismatch pulses.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CHECK, RELEASE, all registered.
REQ-015 IDLE: when req=1, SHALL latch req_val into drv_val and enter SETTLE; drv_en rises on that same edge.
REQ-016 req SHALL be ignored in every state except IDLE; req_val changes after acceptance SHALL NOT affect drv_val.
REQ-017 SETTLE: SHALL last exactly 1 cycle with no compare, then enter CHECK with hold counter loaded to HOLD-1.
REQ-018 CHECK: each cycle SHALL compare bus_in to drv_val (all W bits); on inequality, mismatch=1 on the next cycle.
REQ-019 CHECK: SHALL decrement the counter each cycle and enter RELEASE on the cycle the counter is 0 (exactly HOLD compare cycles).
REQ-020 RELEASE: SHALL deassert drv_en and assert ack for exactly this one cycle, then return to IDLE.
REQ-021 Latency: accepted req to ack SHALL be HOLD+2 cycles; drv_en high for HOLD+1 cycles.
REQ-022 A req high in the cycle after RELEASE (back in IDLE) SHALL be accepted; back-to-back overrides are HOLD+3 cycles apart.
REQ-023 err_cnt SHALL increment by 1 per mismatch pulse and saturate at 255 without wrapping.
REQ-024 drv_val SHALL hold its last value in IDLE; only drv_en gates the strong driver.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, drv_en=0, drv_val=0, ack=0, busy=0, mismatch=0, err_cnt=0.
REQ-026 rst asserted mid-override SHALL abort it with no ack pulse; drv_en=0 from the next cycle.
REQ-027 rst SHALL take priority over req in the same cycle; the req is dropped.

Configuration
REQ-028 Macro STRONG_OVERRIDE_CHECK_EN SHALL control read-back checking.
REQ-029 With STRONG_OVERRIDE_CHECK_EN defined: behaviour per REQ-018 and REQ-023.
REQ-030 Without STRONG_OVERRIDE_CHECK_EN: mismatch and err_cnt SHALL be constant 0, bus_in unused; FSM timing and ack latency unchanged.

Verification
REQ-031 W=100, HOLD=4; req=1 one cycle, req_val all-ones, bus_in mirrors drv_en?drv_val:0 -> drv_en high 5 cycles, ack at cycle 6, mismatch never, err_cnt=0.
REQ-032 Same, but bus_in bit 50 forced 0 during CHECK -> 4 mismatch pulses, err_cnt=4, ack still at cycle 6.
REQ-033 req held high continuously -> overrides accepted every 7 cycles; req_val changes mid-override do not alter drv_val.
REQ-034 rst pulsed 2 cycles after acceptance -> drv_en=0 next cycle, no ack, busy=0, err_cnt=0.
REQ-035 Forced mismatch on 300 consecutive compares -> err_cnt stops at 255.
REQ-036 Build without STRONG_OVERRIDE_CHECK_EN, rerun REQ-032 stimulus -> mismatch=0, err_cnt=0, ack at cycle 6.
